// File: rtl/sdf_stage_ctrl.sv
// sdf_stage_ctrl -- control for one single-path delay-feedback FFT stage.
//
// Sequences a stage of half-length HALF: fills the delay line, runs the
// butterfly/pass alternation with twiddle addressing, and drains the delay
// line on request.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   sample presented this cycle
//   flush      one-cycle request to drain after the current frame
//   in_ready   sample accepted when in_valid & in_ready
//   mode       0 fill/pass, 1 butterfly, 2 drain (datapath mux select)
//   tw_addr    twiddle ROM address
//   out_valid  stage output valid this cycle
//   busy       controller not idle
//   done       one-cycle pulse after the last drain cycle
module sdf_stage_ctrl #(
  parameter int HALF    = 8,
  parameter int TW_AW   = 5,
  parameter int TW_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             flush,
  output logic             in_ready,
  output logic [1:0]       mode,
  output logic [TW_AW-1:0] tw_addr,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  // 2*HALF is a power of two, so a CW-bit counter wraps modulo 2*HALF.
  localparam int CW = $clog2(2 * HALF);
  localparam logic [CW-1:0] HALF_C = CW'(HALF);
  localparam logic [CW-1:0] LAST_H = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          flush_pend;

  logic          accept;
  logic          at_bound;
  logic          bfly;
  logic [31:0]   tw_full;

  // Frame boundary in RUN: the only point where a drain may start.
  assign at_bound  = (state == RUN) && (cnt == '0);
  assign in_ready  = !((state == FLUSH) || (at_bound && flush_pend));
  assign accept    = in_valid && in_ready;

  assign bfly      = (state != FLUSH) && (cnt >= HALF_C);
  assign mode      = (state == FLUSH) ? 2'd2 : {1'b0, bfly};
  assign tw_full   = 32'(cnt - HALF_C) * 32'(TW_STEP);
  assign tw_addr   = bfly ? tw_full[TW_AW-1:0] : '0;

  assign out_valid = (state == FLUSH) || ((state == RUN) && accept);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      flush_pend <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt   <= CW'(1);
            // With HALF=1 the fill phase is just the first sample.
            state <= (HALF == 1) ? RUN : FILL;
          end
        end
        FILL: begin
          if (flush) flush_pend <= 1'b1;
          if (accept) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_H) state <= RUN;
          end
        end
        RUN: begin
          if (at_bound && (flush_pend || flush) && !accept) begin
            state      <= FLUSH;
            flush_pend <= 1'b0;
            cnt        <= '0;
          end else begin
            // A flush that coincides with an accept at the boundary is
            // held until the next frame boundary.
            if (flush) flush_pend <= 1'b1;
            if (accept) cnt <= cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (cnt == LAST_H) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a sample-count model of the stage.
module tb_sdf_stage_ctrl;

  localparam int H    = 8;
  localparam int AW   = 5;
  localparam int STEP = 4;

  logic          clk = 1'b0;
  logic          rst, in_valid, flush;
  logic          in_ready, out_valid, busy, done;
  logic [1:0]    mode;
  logic [AW-1:0] tw_addr;

  sdf_stage_ctrl #(.HALF(H), .TW_AW(AW), .TW_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .in_ready(in_ready), .mode(mode), .tw_addr(tw_addr),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: n = samples accepted in the current frame sequence (0 = idle),
  // drn/di = draining and drain index, pend = flush waiting for boundary.
  int n = 0, di = 0, accs = 0, dut_outs = 0;
  bit drn = 0, pend = 0, done_q = 0, known = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit iv, input bit fl);
    int p, e_mode, e_tw;
    bit bnd, e_rdy, acc, e_ov, e_busy, fin;
    rst = r; in_valid = iv; flush = fl;
    @(negedge clk);
    p      = n % (2 * H);
    bnd    = !drn && (n > 0) && (p == 0);
    e_rdy  = !drn && !(bnd && pend);
    acc    = iv && e_rdy;
    e_mode = drn ? 2 : ((p >= H) ? 1 : 0);
    e_tw   = (e_mode == 1) ? (((p - H) * STEP) % (1 << AW)) : 0;
    e_ov   = drn || (acc && n >= H);
    e_busy = drn || (n > 0);
    if (known) begin
      chk("in_ready",  int'(in_ready),  int'(e_rdy));
      chk("mode",      int'(mode),      e_mode);
      chk("tw_addr",   int'(tw_addr),   e_tw);
      chk("out_valid", int'(out_valid), int'(e_ov));
      chk("busy",      int'(busy),      int'(e_busy));
      chk("done",      int'(done),      int'(done_q));
    end
    if (r) begin
      n = 0; di = 0; drn = 0; pend = 0; done_q = 0;
      accs = 0; dut_outs = 0; known = 1;
    end else begin
      accs     += int'(acc);
      dut_outs += int'(out_valid);
      fin    = drn && (di == H - 1);
      done_q = fin;
      if (drn) begin
        if (fin) begin
          // Every accepted sample must have come out once the drain ends.
          chk("conserve", dut_outs, accs);
          drn = 0; n = 0; accs = 0; dut_outs = 0;
        end else di++;
      end else if (bnd && (pend || fl) && !acc) begin
        drn = 1; di = 0; pend = 0;
      end else begin
        if (fl && n > 0) pend = 1;
        if (acc) n++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    // Reset held with in_valid and flush asserted.
    repeat (3) step(1, 1, 1);
    // Two full frames then a flush at the boundary with no sample.
    repeat (32) step(0, 1, 0);
    step(0, 0, 1);
    repeat (10) step(0, 0, 0);
    // Stall after sample 10.
    repeat (11) step(0, 1, 0);
    repeat (3) step(0, 0, 0);
    repeat (21) step(0, 1, 0);
    // Flush mid-frame at cnt=5 while samples keep coming.
    repeat (5) step(0, 1, 0);
    step(0, 1, 1);
    repeat (12) step(0, 1, 0);
    repeat (12) step(0, 0, 0);
    // Reset on the 4th drain cycle.
    repeat (16) step(0, 1, 0);
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    // Flush during fill, held until the run reaches its boundary.
    repeat (3) step(0, 1, 0);
    step(0, 1, 1);
    repeat (30) step(0, 1, 0);
    repeat (3) step(0, 0, 0);
    // Random traffic.
    repeat (4000)
      step(($urandom % 700) == 0, ($urandom % 4) != 0, ($urandom % 25) == 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 The block SHALL take parameter HALF, default 8, meaning stage half-length and delay-line depth; power of two, 1..32.
REQ-002 The block SHALL take parameter TW_AW, default 5, meaning twiddle ROM address width.
REQ-003 The block SHALL take parameter TW_STEP, default 4, meaning twiddle address stride per butterfly slot (64/(2*HALF) for a 64-point FFT).
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: an input sample is presented this cycle.
REQ-007 The block SHALL have port flush, input, 1 bit: single-cycle request to drain the delay line after the current frame.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a sample this cycle (accept = in_valid & in_ready).
REQ-009 The block SHALL have port mode, output, 2 bits: 0 = fill/pass, 1 = butterfly, 2 = drain; drives the stage datapath mux.
REQ-010 The block SHALL have port tw_addr, output, TW_AW bits: twiddle ROM address.
REQ-011 The block SHALL have port out_valid, output, 1 bit: stage output is valid this cycle.
REQ-012 The block SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse when a drain completes.

Function
REQ-014 The block SHALL hold a position counter cnt of log2(2*HALF) bits, a flush_pend flag and an FSM with states IDLE, FILL, RUN and FLUSH.
REQ-015 mode, tw_addr, out_valid and in_ready SHALL be combinational decodes of the registered state, cnt and flush_pend (zero-latency, valid in the cycle of the sample).
REQ-016 In IDLE, FILL and RUN, mode SHALL be 0 when cnt < HALF and 1 when cnt >= HALF; in FLUSH, mode SHALL be 2.
REQ-017 tw_addr SHALL be (cnt-HALF)*TW_STEP, truncated to TW_AW bits, when mode=1, and 0 otherwise.
REQ-018 In IDLE, an accept SHALL set cnt to 1 and move the FSM to FILL.
REQ-019 In FILL, each accept SHALL increment cnt; accepting at cnt=HALF-1 SHALL move the FSM to RUN; out_valid SHALL be 0.
REQ-020 In RUN, each accept SHALL increment cnt modulo 2*HALF (wrap 2*HALF-1 -> 0), and out_valid SHALL equal accept.
REQ-021 in_valid=0 in FILL or RUN SHALL stall the block: cnt holds, out_valid=0, mode and tw_addr unchanged.
REQ-022 A flush pulse in FILL or RUN SHALL set flush_pend; repeated pulses have no additional effect; flush SHALL be ignored in IDLE and FLUSH.
REQ-023 in_ready SHALL be 0 in FLUSH and in RUN when cnt=0 and flush_pend=1; it SHALL be 1 otherwise.
REQ-024 The FSM SHALL move RUN -> FLUSH when cnt=0 and (flush_pend or flush) and no accept occurs that cycle; the transition clears flush_pend.
REQ-025 If flush arrives at cnt=0 in the same cycle as an accept, the sample SHALL be taken, cnt SHALL go to 1 and flush_pend SHALL be set.
REQ-026 A flush pending in FILL SHALL be held until RUN returns to cnt=0.
REQ-027 FLUSH SHALL advance cnt every cycle from 0 to HALF-1 with out_valid=1 (HALF drain outputs); at cnt=HALF-1 the FSM SHALL go to IDLE with cnt=0.
REQ-028 done SHALL be a registered signal, equal to 1 for exactly the one cycle after the last FLUSH cycle.
REQ-029 Total out_valid cycles SHALL equal total accepted samples once a drain completes.

Reset
REQ-030 While rst=1 at a clock edge: state=IDLE, cnt=0, flush_pend=0, done=0.
REQ-031 Reset values of the outputs SHALL be mode=0, tw_addr=0, out_valid=0, in_ready=1, busy=0, done=0.
REQ-032 Reset SHALL override all other inputs in any state, including mid-frame and mid-FLUSH.

Verification (HALF=8, TW_STEP=4, TW_AW=5)
REQ-033 rst=1 for 3 cycles with in_valid=1 and flush=1 -> all outputs at their reset values, no state advance.
REQ-034 16 contiguous accepts from IDLE -> samples 0-7: out_valid=0, mode=0; samples 8-15: mode=1, out_valid=1, tw_addr 0,4,8,...,28; sample 16: mode=0, out_valid=1.
REQ-035 in_valid low for 3 cycles after sample 10 -> cnt=11 holds, tw_addr=12, out_valid=0; resumes at tw_addr 12 then 16.
REQ-036 32 accepts, then flush with in_valid=0 at cnt=0 -> in_ready=0, 8 cycles of mode=2 and out_valid=1, then done=1 for 1 cycle, busy=0.
REQ-037 flush at cnt=5 of the second frame -> in_ready stays 1 through cnt=15; in_ready=0 at cnt=0; FLUSH begins on the next cycle.
REQ-038 rst asserted on the 4th FLUSH cycle -> IDLE on the next cycle; done never pulses; flush_pend=0.
